// File: rtl/bin_ratio_frame_buffer_pkg.sv
// Shared constants, state encoding and frame-size derivation for the
// per-diagonal log-ratio frame buffer.
package bin_ratio_frame_buffer_pkg;

    localparam int BRFB_DAT_W  = 8;
    localparam int BRFB_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SERVE = 2'd2,
        ST_DONE  = 2'd3
    } brfb_state_e;

    // Each diagonal of the ensemble loses one bin per diagonal step.
    function automatic int num_entries(input int diagonal);
        return 1023 - diagonal;
    endfunction

endpackage

// File: rtl/bin_ratio_frame_buffer_mem.sv
// Frame storage: un-reset sample array plus reset written-bitmap.
// Synchronous write, asynchronous read; never-written entries read as zero.
module bin_ratio_frame_buffer_mem #(
    parameter int NUM_ENTRIES = 1020,
    parameter int DAT_W       = 8,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DAT_W-1:0]  wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DAT_W-1:0]  rd_dat,
    output logic              wr_new
);

    logic [DAT_W-1:0]       mem_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] written_q;
    logic [NUM_ENTRIES-1:0] written_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    // A clear and a write in the same cycle: the write belongs to the new frame.
    always_comb begin
        written_d = clr ? '0 : written_q;
        if (wr_en) begin
            written_d[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    assign wr_new = clr | ~written_q[wr_addr];
    assign rd_dat = written_q[rd_addr] ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/bin_ratio_frame_buffer.sv
// Captures one addressed frame of log-ratio samples, then replays it in
// address order over a valid/ready handshake to the SNN input layer.
//
// state    | meaning
// ST_IDLE  | waiting for trans_start
// ST_FILL  | capturing processed_dat writes until prepro_finish
// ST_SERVE | replaying entries 0..NUM_ENTRIES-1 to the SNN
// ST_DONE  | one-cycle frame_done pulse, then back to idle
module bin_ratio_frame_buffer
    import bin_ratio_frame_buffer_pkg::*;
#(
    parameter int DIAGONAL = 3,
    parameter int DAT_W    = BRFB_DAT_W,
    parameter int ADDR_W   = BRFB_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trans_start,
    input  logic signed [DAT_W-1:0]  processed_dat,
    input  logic        [ADDR_W-1:0] processed_dat_addr,
    input  logic                     processed_dat_ready,
    input  logic                     prepro_finish,
    output logic signed [DAT_W-1:0]  snn_dat,
    output logic        [ADDR_W-1:0] snn_addr,
    output logic                     snn_valid,
    input  logic                     snn_ready,
    output logic                     frame_done,
    output logic                     short_frame,
    output logic                     overrun,
    output logic                     addr_err
);

    localparam int                NUM_ENTRIES = num_entries(DIAGONAL);
    localparam logic [ADDR_W-1:0] N_ADDR      = ADDR_W'(NUM_ENTRIES);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_ENTRIES - 1);

    brfb_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_count_q, wr_count_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] snn_addr_q, snn_addr_d;
    logic [DAT_W-1:0]  snn_dat_q, snn_dat_d;
    logic              snn_valid_q, snn_valid_d;
    logic              short_frame_q, short_frame_d;
    logic              overrun_q, overrun_d;
    logic              addr_err_q, addr_err_d;

    logic              mem_clr;
    logic              mem_wr_en;
    logic              mem_wr_new;
    logic [DAT_W-1:0]  mem_rd_dat;

    bin_ratio_frame_buffer_mem #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .DAT_W       (DAT_W),
        .ADDR_W      (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (mem_clr),
        .wr_en   (mem_wr_en),
        .wr_addr (processed_dat_addr),
        .wr_dat  (processed_dat),
        .rd_addr (rd_ptr_q),
        .rd_dat  (mem_rd_dat),
        .wr_new  (mem_wr_new)
    );

    always_comb begin
        state_d       = state_q;
        wr_count_d    = wr_count_q;
        rd_ptr_d      = rd_ptr_q;
        snn_addr_d    = snn_addr_q;
        snn_dat_d     = snn_dat_q;
        snn_valid_d   = snn_valid_q;
        short_frame_d = short_frame_q;
        overrun_d     = overrun_q;
        addr_err_d    = addr_err_q;
        mem_clr       = 1'b0;
        mem_wr_en     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trans_start) begin
                    mem_clr       = 1'b1;
                    wr_count_d    = '0;
                    short_frame_d = 1'b0;
                    overrun_d     = 1'b0;
                    addr_err_d    = 1'b0;
                    state_d       = ST_FILL;
                end
            end
            ST_FILL: begin
                if (trans_start) begin
                    mem_clr    = 1'b1;
                    wr_count_d = '0;
                end
                if (processed_dat_ready) begin
                    if (processed_dat_addr < N_ADDR) begin
                        mem_wr_en = 1'b1;
                        if (mem_wr_new) begin
                            wr_count_d = wr_count_d + ADDR_W'(1);
                        end
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                if (prepro_finish && !trans_start) begin
                    short_frame_d = (wr_count_d != N_ADDR);
                    rd_ptr_d      = '0;
                    state_d       = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (processed_dat_ready || trans_start) begin
                    overrun_d = 1'b1;
                end
                if (snn_valid_q && snn_ready && (snn_addr_q == LAST_ADDR)) begin
                    snn_valid_d = 1'b0;
                    state_d     = ST_DONE;
                end else if (!snn_valid_q || snn_ready) begin
                    snn_dat_d   = mem_rd_dat;
                    snn_addr_d  = rd_ptr_q;
                    snn_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                if (processed_dat_ready || trans_start) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_count_q    <= '0;
            rd_ptr_q      <= '0;
            snn_addr_q    <= '0;
            snn_dat_q     <= '0;
            snn_valid_q   <= 1'b0;
            short_frame_q <= 1'b0;
            overrun_q     <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_count_q    <= wr_count_d;
            rd_ptr_q      <= rd_ptr_d;
            snn_addr_q    <= snn_addr_d;
            snn_dat_q     <= snn_dat_d;
            snn_valid_q   <= snn_valid_d;
            short_frame_q <= short_frame_d;
            overrun_q     <= overrun_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign snn_dat     = snn_dat_q;
    assign snn_addr    = snn_addr_q;
    assign snn_valid   = snn_valid_q;
    assign frame_done  = (state_q == ST_DONE);
    assign short_frame = short_frame_q;
    assign overrun     = overrun_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_bin_ratio_frame_buffer.sv
// Self-checking bench: frames captured via random/structured writes, replay
// compared against an array-based model of the frame contents and flags.
`timescale 1ns/1ps
module tb_bin_ratio_frame_buffer;

    localparam int DIAGONAL = 3;
    localparam int N        = 1023 - DIAGONAL;

    logic              clk;
    logic              rst_n;
    logic              trans_start;
    logic signed [7:0] processed_dat;
    logic [9:0]        processed_dat_addr;
    logic              processed_dat_ready;
    logic              prepro_finish;
    logic signed [7:0] snn_dat;
    logic [9:0]        snn_addr;
    logic              snn_valid;
    logic              snn_ready;
    logic              frame_done;
    logic              short_frame;
    logic              overrun;
    logic              addr_err;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] model_mem [N];
    bit                model_written [N];
    bit                model_addr_err;
    bit                model_overrun;

    bin_ratio_frame_buffer #(.DIAGONAL(DIAGONAL)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .trans_start         (trans_start),
        .processed_dat       (processed_dat),
        .processed_dat_addr  (processed_dat_addr),
        .processed_dat_ready (processed_dat_ready),
        .prepro_finish       (prepro_finish),
        .snn_dat             (snn_dat),
        .snn_addr            (snn_addr),
        .snn_valid           (snn_valid),
        .snn_ready           (snn_ready),
        .frame_done          (frame_done),
        .short_frame         (short_frame),
        .overrun             (overrun),
        .addr_err            (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1);
    end

    function automatic int model_count();
        int n = 0;
        foreach (model_written[i]) n += int'(model_written[i]);
        return n;
    endfunction

    function automatic logic signed [7:0] model_expect(input int a);
        return model_written[a] ? model_mem[a] : 8'sd0;
    endfunction

    task automatic model_clear_all();
        foreach (model_written[i]) model_written[i] = 1'b0;
        model_addr_err = 1'b0;
        model_overrun  = 1'b0;
    endtask

    task automatic start_frame();
        trans_start = 1'b1;
        @(posedge clk); #1;
        trans_start = 1'b0;
        model_clear_all();
    endtask

    task automatic write_sample(input int a, input int d, input bit with_start);
        processed_dat_addr  = 10'(a);
        processed_dat       = 8'(d);
        processed_dat_ready = 1'b1;
        trans_start         = with_start;
        @(posedge clk); #1;
        processed_dat_ready = 1'b0;
        trans_start         = 1'b0;
        if (with_start) foreach (model_written[i]) model_written[i] = 1'b0;
        if (a < N) begin
            model_mem[a]     = 8'(d);
            model_written[a] = 1'b1;
        end else begin
            model_addr_err = 1'b1;
        end
    endtask

    task automatic finish_frame();
        prepro_finish = 1'b1;
        @(posedge clk); #1;
        prepro_finish = 1'b0;
    endtask

    // mode: 0 ready always, 1 toggling, 2 random. inject_cyc: a write strobe
    // during replay. abort_addr: reset when that address is presented.
    task automatic serve_check(input string name, input int mode, input int inject_cyc,
                               input int abort_addr);
        int idx = 0;
        bit held = 1'b0;
        bit done_seen = 1'b0;
        logic [9:0] prev_addr = '0;
        logic signed [7:0] prev_dat = '0;
        logic exp_short = (model_count() != N);
        finish_frame();
        for (int c = 0; c < 4 * N + 50 && !done_seen; c++) begin
            snn_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2) : ($urandom_range(0, 3) != 0);
            processed_dat_ready = (c == inject_cyc);
            processed_dat_addr  = 10'd0;
            processed_dat       = -8'sd1;
            if (c == inject_cyc) model_overrun = 1'b1;
            @(negedge clk);
            if (snn_valid && abort_addr >= 0 && int'(snn_addr) == abort_addr) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (snn_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async_reset_valid: got %b expected 0", name, snn_valid);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
                processed_dat_ready = 1'b0;
                model_clear_all();
                checks++;
                if ({snn_valid, frame_done, short_frame, overrun, addr_err} !== 5'b0) begin
                    errors++;
                    $display("FAIL %s post_reset_outputs: got %b expected 00000", name,
                             {snn_valid, frame_done, short_frame, overrun, addr_err});
                end
                return;
            end
            if (frame_done) begin
                done_seen = 1'b1;
                checks++;
                if (idx != N || snn_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s frame_done_timing: beats %0d valid %b expected %0d beats valid 0",
                             name, idx, snn_valid, N);
                end
            end else if (snn_valid) begin
                if (held) begin
                    checks++;
                    if (snn_addr !== prev_addr || snn_dat !== prev_dat) begin
                        errors++;
                        $display("FAIL %s stall_stable: got addr %0d dat %0d expected addr %0d dat %0d",
                                 name, snn_addr, snn_dat, prev_addr, prev_dat);
                    end
                end
                if (snn_ready) begin
                    checks++;
                    if (idx >= N || int'(snn_addr) !== idx || snn_dat !== model_expect(idx)) begin
                        errors++;
                        $display("FAIL %s beat: got addr %0d dat %0d expected addr %0d dat %0d",
                                 name, snn_addr, snn_dat, idx, (idx < N) ? model_expect(idx) : 8'sd0);
                    end
                    idx++;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    prev_addr = snn_addr;
                    prev_dat  = snn_dat;
                end
            end
            @(posedge clk); #1;
        end
        processed_dat_ready = 1'b0;
        snn_ready = 1'b0;
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats expected %0d with frame_done", name, idx, N);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 ||
            {short_frame, overrun, addr_err} !== {exp_short, model_overrun, model_addr_err}) begin
            errors++;
            $display("FAIL %s flags: got done %b short %b overrun %b addr_err %b expected done 0 short %b overrun %b addr_err %b",
                     name, frame_done, short_frame, overrun, addr_err,
                     exp_short, model_overrun, model_addr_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_pattern();
        start_frame();
        for (int i = 0; i < N; i++) write_sample(i, (i % 128) - 64, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({snn_valid, frame_done, short_frame, overrun, addr_err} !== 5'b0 ||
            snn_dat !== 8'sd0 || snn_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid %b done %b flags %b%b%b dat %0d addr %0d expected all 0",
                     snn_valid, frame_done, short_frame, overrun, addr_err, snn_dat, snn_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({snn_valid, frame_done} !== 2'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got valid %b done %b expected 0 0", snn_valid, frame_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        fill_pattern();
        serve_check("full_frame", 0, -1, -1);
    endtask

    task automatic test_stall();
        fill_pattern();
        serve_check("stall_toggle", 1, -1, -1);
    endtask

    task automatic test_short_frame();
        start_frame();
        for (int i = 0; i < 10; i++) write_sample(i, 5, 1'b0);
        serve_check("short_frame", 0, -1, -1);
    endtask

    task automatic test_addr_err();
        start_frame();
        for (int i = 0; i < N; i++) begin
            write_sample(i, $urandom_range(0, 255), 1'b0);
            if (i == 100) write_sample(1020, -99, 1'b0);
            if (i == 700) write_sample(1023, -99, 1'b0);
        end
        serve_check("addr_err", 0, -1, -1);
    endtask

    task automatic test_overrun();
        fill_pattern();
        serve_check("overrun", 2, 5, -1);
    endtask

    task automatic test_reset_mid_serve();
        fill_pattern();
        serve_check("reset_mid_serve", 0, -1, 500);
        fill_pattern();
        serve_check("after_reset", 0, -1, -1);
    endtask

    task automatic test_restart();
        start_frame();
        for (int i = 0; i < 100; i++) write_sample(i, 7, 1'b0);
        write_sample(5, -3, 1'b1);
        for (int i = 200; i < N; i++) write_sample(i, $urandom_range(0, 255), 1'b0);
        serve_check("restart", 1, -1, -1);
    endtask

    task automatic test_random(input int iter);
        int nw;
        start_frame();
        nw = $urandom_range(N / 2, 2 * N);
        for (int i = 0; i < nw; i++)
            write_sample($urandom_range(0, N + 3), $urandom_range(0, 255), 1'b0);
        serve_check($sformatf("random_%0d", iter), 2, -1, -1);
    endtask

    initial begin
        rst_n               = 1'b0;
        trans_start         = 1'b0;
        processed_dat       = '0;
        processed_dat_addr  = '0;
        processed_dat_ready = 1'b0;
        prepro_finish       = 1'b0;
        snn_ready           = 1'b0;
        model_clear_all();
        test_reset();
        test_full_frame();
        test_stall();
        test_short_frame();
        test_addr_err();
        test_overrun();
        test_reset_mid_serve();
        test_restart();
        for (int k = 0; k < 3; k++) test_random(k);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
